// File: rtl/accum_pkg.sv
// Shared constants for the parameterised accumulator.
// State encoding and mode selectors.
package accum_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_SUM   = 1'b1;

endpackage

// File: rtl/accum_datapath.sv
// Loop index, running sum, output register and overflow flag.
// Driven by init/add strobes from the control FSM.
module accum_datapath
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             add,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic             lt,
  output logic [WIDTH-1:0] out_val,
  output logic             overflow
);

  localparam logic [WIDTH:0] INC =
    (WIDTH+1)'(STEP);

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic [WIDTH:0]   total;

  // a < 2^WIDTH whenever add fires, so the carry lands in bit WIDTH
  assign total = {1'b0, sum} + a;
  assign lt    = a < {1'b0, limit_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a        <= '0;
      sum      <= '0;
      out_val  <= '0;
      overflow <= 1'b0;
      limit_q  <= '0;
      mode_q   <= MODE_COUNT;
    end else if (init) begin
      a        <= '0;
      sum      <= '0;
      out_val  <= '0;
      overflow <= 1'b0;
      limit_q  <= limit;
      mode_q   <= mode;
    end else if (add) begin
      sum <= total[WIDTH-1:0];
      a   <= a + INC;
      if (mode_q == MODE_SUM)
        out_val <= total[WIDTH-1:0];
      else
        out_val <= a[WIDTH-1:0];
      if (total[WIDTH])
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/param_accum_proc.sv
// Control FSM for the counting/summing loop.
// All transitions are qualified by en.
module param_accum_proc
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] outPort,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  logic [2:0] state;
  logic [2:0] next;
  logic       lt;
  logic       init;
  logic       add;

  always_comb begin
    next = state;
    if (en) begin
      case (state)
        S_IDLE:  if (start) next = S_INIT;
        S_INIT:  next = S_CHECK;
        S_CHECK: next = lt ? S_ADD : S_DONE;
        S_ADD:   next = S_CHECK;
        S_DONE:  next = S_IDLE;
        default: next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= next;
  end

  assign init = en && (state == S_INIT);
  assign add  = en && (state == S_ADD);
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;

  accum_datapath #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .add      (add),
    .mode     (mode),
    .limit    (limit),
    .lt       (lt),
    .out_val  (outPort),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_param_accum_proc.sv
// Directed bench for param_accum_proc.
// Cycle 1 is the edge that samples start.
module tb_param_accum_proc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] limit = '0;
  logic [7:0] out_port;
  logic       busy;
  logic       done;
  logic       ovf;

  logic       en2 = 1'b0;
  logic       start2 = 1'b0;
  logic       mode2 = 1'b0;
  logic [7:0] limit2 = '0;
  logic [7:0] out2;
  logic       busy2;
  logic       done2;
  logic       ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_accum_proc #(.WIDTH(8), .STEP(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .start    (start),
    .mode     (mode),
    .limit    (limit),
    .outPort  (out_port),
    .busy     (busy),
    .done     (done),
    .overflow (ovf)
  );

  param_accum_proc #(.WIDTH(8), .STEP(16)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .en       (en2),
    .start    (start2),
    .mode     (mode2),
    .limit    (limit2),
    .outPort  (out2),
    .busy     (busy2),
    .done     (done2),
    .overflow (ovf2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag,
                     input logic [7:0] lim,
                     input logic md,
                     input int exp_cyc,
                     input logic [7:0] exp_out,
                     input logic exp_ovf,
                     input bit cnt_seq);
    int  cyc = 0;
    bit  seen = 0;
    limit = lim;
    mode  = md;
    en    = 1'b1;
    start = 1'b1;
    while (!seen && cyc < 200) begin
      tick();
      cyc++;
      start = 1'b0;
      if (cyc == 2) begin
        limit = ~lim;
        mode  = ~md;
      end
      if (cnt_seq && cyc >= 4 &&
          cyc <= 22 && cyc % 2 == 0)
        chk({tag, "_seq"}, 32'(out_port),
            32'((cyc - 4) / 2));
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_done_cyc"}, cyc, exp_cyc);
    chk({tag, "_out"}, 32'(out_port),
        32'(exp_out));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy"}, 32'(busy), 1);
    tick();
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    limit = lim;
    mode  = md;
  endtask

  initial begin
    int  c;
    bit  seen;
    int  bad;

    #12;
    chk("rst_out", 32'(out_port), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_out2", 32'(out2), 0);
    reset = 1'b1;
    tick();

    run("sum10", 8'd10, 1'b1, 23, 8'd45, 1'b0, 0);
    run("cnt10", 8'd10, 1'b0, 23, 8'd9, 1'b0, 1);
    run("wrap30", 8'd30, 1'b1, 63, 8'd179, 1'b1, 0);
    run("after5", 8'd5, 1'b1, 13, 8'd10, 1'b0, 0);
    run("lim0", 8'd0, 1'b1, 3, 8'd0, 1'b0, 0);

    // STEP=16 instance, limit=255
    limit2 = 8'd255;
    mode2  = 1'b1;
    en2    = 1'b1;
    start2 = 1'b1;
    c = 0;
    seen = 0;
    while (!seen && c < 200) begin
      tick();
      c++;
      start2 = 1'b0;
      if (done2) seen = 1;
    end
    chk("s16_done_cyc", c, 35);
    chk("s16_out", 32'(out2), 128);
    chk("s16_ovf", 32'(ovf2), 1);
    chk("s16_a", 32'(dut2.u_dp.a), 256);

    // en toggling stall, start pulsed while busy
    limit = 8'd10;
    mode  = 1'b1;
    start = 1'b1;
    c = 0;
    seen = 0;
    while (!seen && c < 300) begin
      en = (c % 2 == 1);
      tick();
      c++;
      if (c == 2) start = 1'b0;
      if (c == 10) start = 1'b1;
      if (c == 12) start = 1'b0;
      if (done) seen = 1;
    end
    chk("stall_done_cyc", c, 46);
    chk("stall_out", 32'(out_port), 45);
    en = 1'b0;
    tick();
    chk("stall_hold_done", 32'(done), 1);
    chk("stall_hold_out", 32'(out_port), 45);
    en = 1'b1;
    tick();
    chk("stall_idle_busy", 32'(busy), 0);

    // reset abort at cycle 8
    limit = 8'd10;
    mode  = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
    end
    chk("abort_pre_out", 32'(out_port), 3);
    chk("abort_pre_busy", 32'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_out", 32'(out_port), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ovf", 32'(ovf), 0);
    tick();
    tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) bad++;
    end
    chk("abort_no_run", bad, 0);
    run("rerun", 8'd10, 1'b1, 23, 8'd45, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/param_accum_proc.md
PARAM_ACCUM_PROC -- requirements
Module: param_accum_proc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width of outPort, limit and the sum register.
REQ-002 The block SHALL have parameter STEP, default 1: loop-index increment; legal range 1..2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable; the FSM and datapath hold when en=0.
REQ-006 The block SHALL have port start, input, 1 bit: start request, sampled only in IDLE with en=1.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = count mode, 1 = sum mode; latched in INIT.
REQ-008 The block SHALL have port limit, input, WIDTH bits: exclusive loop bound; latched in INIT.
REQ-009 The block SHALL have port outPort, output, WIDTH bits: result or progress value.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag for sum wrap in the current run.

Function
REQ-013 The FSM SHALL have the states IDLE, INIT, CHECK, ADD and DONE; every transition SHALL require en=1.
REQ-014 The FSM SHALL go IDLE->INIT when start=1; start SHALL be ignored in all other states.
REQ-015 In INIT, the block SHALL clear A, Sum, outPort and overflow, latch mode and limit, then go to CHECK.
REQ-016 In CHECK, the block SHALL go to ADD if A < latched limit, else to DONE.
REQ-017 In ADD, the block SHALL update Sum <= (Sum + A) mod 2^WIDTH and A <= A + STEP, then return to CHECK.
REQ-018 In ADD, outPort SHALL load A (pre-increment value) in count mode and the new Sum in sum mode.
REQ-019 In ADD, overflow SHALL be set if Sum + A >= 2^WIDTH; it SHALL hold until the next INIT or reset.
REQ-020 A SHALL be WIDTH+1 bits and compared against the zero-extended limit, so the loop terminates for every limit and STEP without wrapping.
REQ-021 In DONE, outPort SHALL be unchanged, done=1 and busy=1, with the next state IDLE.
REQ-022 With en=1 throughout, done SHALL assert exactly 2*N+3 cycles after the edge that samples start, where N = ceil(limit/STEP).
REQ-023 For limit=0, the sequence SHALL be INIT->CHECK->DONE, with outPort=0 and done at cycle 3.
REQ-024 When en=0, all registers and outputs SHALL hold their values, including done and busy.
REQ-025 Changes on mode or limit after INIT SHALL NOT affect the run in progress.

Reset
REQ-026 When reset=0, the block SHALL immediately force state to IDLE and A, Sum, outPort, overflow, done and busy to 0.
REQ-027 A reset asserted mid-run SHALL abort the run; no done pulse SHALL follow.
REQ-028 After reset deasserts, the block SHALL require a new start before running again.

Structure
REQ-029 The state encoding (IDLE..DONE) and the MODE_COUNT/MODE_SUM constants SHALL live in the shared package accum_pkg.
REQ-030 The design SHALL be split into a control FSM in param_accum_proc and one sub-module, accum_datapath.
REQ-031 accum_datapath SHALL contain the A/Sum/outPort registers, the adder, the comparator and the overflow flag, driven by load/select strobes from the FSM.

Verification
REQ-032 Scenario sum mode: WIDTH=8, STEP=1, limit=10, mode=1, en=1, start pulse -> outPort=45 (0x2D), done at cycle 23, overflow=0.
REQ-033 Scenario count mode: limit=10, mode=0 -> outPort sequence 0..9 on successive ADD cycles, final outPort=9, done at cycle 23.
REQ-034 Scenario wrap: limit=30, mode=1 -> outPort=179 (435 mod 256), overflow=1; a following run with limit=5 -> outPort=10, overflow=0.
REQ-035 Scenario edge bounds: limit=0 -> outPort=0 and done at cycle 3; limit=255 with STEP=16 -> terminates after 16 ADDs with A=256.
REQ-036 Scenario stall and ignore: en toggled 1/0 every cycle -> identical result with done at cycle 2*(2N+3); start pulsed while busy -> ignored.
REQ-037 Scenario reset abort: reset=0 asserted at cycle 8 of a limit=10 run -> all outputs 0 immediately and no done; the next start runs normally.
